// File: rtl/shift_rx_deser_if.sv
// Serial-in / parallel-out bundle for shift_rx_deser: serial strobe side plus
// the valid/ready word output and status flags.
interface shift_rx_deser_if #(
    parameter int WIDTH = 4
);
    logic             ser_in;
    logic             ser_en;
    logic             sync;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             q_ready;
    logic             ovf;
    logic             busy;

    modport master (
        output ser_in, ser_en, sync, q_ready,
        input  q, q_valid, ovf, busy
    );

    modport slave (
        input  ser_in, ser_en, sync, q_ready,
        output q, q_valid, ovf, busy
    );
endinterface

// File: rtl/shift_rx_deser.sv
// Serial-to-parallel receiver for a 74194-style serial link: SYNC-aligned word
// assembly, one-deep valid/ready output register, sticky overflow on drop.
//
//   state | meaning
//   IDLE  | no word in progress, waiting for a start bit
//   SHIFT | partial word being assembled (BUSY)
module shift_rx_deser #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit REQ_SYNC  = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_clr,
    shift_rx_deser_if.slave  bus
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_sr_shifted;
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;
    logic             r_ovf;
    logic             w_start;
    logic             w_shift;
    logic             w_complete;

    if (MSB_FIRST) begin : g_msb_first
        assign w_sr_shifted = {r_sr[WIDTH-2:0], bus.ser_in};
    end else begin : g_lsb_first
        assign w_sr_shifted = {bus.ser_in, r_sr[WIDTH-1:1]};
    end

    assign w_start = bus.ser_en && (bus.sync || !REQ_SYNC);

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = SHIFT;
            SHIFT:   if (bus.ser_en && !bus.sync && r_cnt == LAST) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A SYNC inside SHIFT restarts the count; stale bits fall out of the
    // register before the word can complete, so no explicit clear is needed.
    always_comb begin
        w_shift    = 1'b0;
        w_complete = 1'b0;
        w_cnt_nxt  = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_shift   = 1'b1;
                    w_cnt_nxt = CW'(1);
                end
            end
            SHIFT: begin
                if (bus.ser_en) begin
                    w_shift = 1'b1;
                    if (bus.sync) begin
                        w_cnt_nxt = CW'(1);
                    end else if (r_cnt == LAST) begin
                        w_complete = 1'b1;
                        w_cnt_nxt  = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: w_cnt_nxt = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_sr      <= '0;
            r_cnt     <= '0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_shift) r_sr <= w_sr_shifted;
            r_cnt <= w_cnt_nxt;
            // A completion while the held word is being accepted replaces it.
            if (w_complete) begin
                if (!r_q_valid || bus.q_ready) begin
                    r_q       <= w_sr_shifted;
                    r_q_valid <= 1'b1;
                end else begin
                    r_ovf <= 1'b1;
                end
            end else if (r_q_valid && bus.q_ready) begin
                r_q_valid <= 1'b0;
            end
        end
    end

    assign bus.q       = r_q;
    assign bus.q_valid = r_q_valid;
    assign bus.ovf     = r_ovf;
    assign bus.busy    = (r_state == SHIFT);

endmodule

// File: tb/tb_shift_rx_deser.sv
// Directed bench for shift_rx_deser: an MSB-first and an LSB-first instance
// share one stimulus and are checked every cycle against a bit-list model.
module tb_shift_rx_deser;

    localparam int W = 4;

    logic clk;
    logic clr;
    logic ser_in;
    logic ser_en;
    logic sync;
    logic q_ready;

    int checks = 0;
    int errors = 0;

    shift_rx_deser_if #(.WIDTH(W)) if0 ();
    shift_rx_deser_if #(.WIDTH(W)) if1 ();

    assign if0.ser_in  = ser_in;
    assign if0.ser_en  = ser_en;
    assign if0.sync    = sync;
    assign if0.q_ready = q_ready;
    assign if1.ser_in  = ser_in;
    assign if1.ser_en  = ser_en;
    assign if1.sync    = sync;
    assign if1.q_ready = q_ready;

    shift_rx_deser #(.WIDTH(W), .MSB_FIRST(1'b1), .REQ_SYNC(1'b1)) u_dut_msb (
        .i_clk (clk),
        .i_clr (clr),
        .bus   (if0)
    );

    shift_rx_deser #(.WIDTH(W), .MSB_FIRST(1'b0), .REQ_SYNC(1'b1)) u_dut_lsb (
        .i_clk (clk),
        .i_clr (clr),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: bits received so far in arrival order; index 0 is MSB-first.
    bit           m_busy [2];
    bit           m_bits [2][W];
    int           m_n    [2];
    logic [W-1:0] m_q    [2];
    bit           m_qv   [2];
    bit           m_ovf  [2];

    task automatic model_step(input int k, input bit msb_first);
        logic [W-1:0] word;
        bit           done;
        done = 1'b0;
        word = '0;
        if (clr) begin
            m_busy[k] = 1'b0;
            m_n[k]    = 0;
            m_q[k]    = '0;
            m_qv[k]   = 1'b0;
            m_ovf[k]  = 1'b0;
            return;
        end
        if (ser_en) begin
            if (sync) begin
                m_bits[k][0] = ser_in;
                m_n[k]       = 1;
                m_busy[k]    = 1'b1;
            end else if (m_busy[k]) begin
                m_bits[k][m_n[k]] = ser_in;
                m_n[k]            = m_n[k] + 1;
                if (m_n[k] == W) begin
                    for (int i = 0; i < W; i++) begin
                        if (msb_first) word[W-1-i] = m_bits[k][i];
                        else           word[i]     = m_bits[k][i];
                    end
                    done      = 1'b1;
                    m_n[k]    = 0;
                    m_busy[k] = 1'b0;
                end
            end
        end
        if (done) begin
            if (!m_qv[k] || q_ready) begin
                m_q[k]  = word;
                m_qv[k] = 1'b1;
            end else begin
                m_ovf[k] = 1'b1;
            end
        end else if (m_qv[k] && q_ready) begin
            m_qv[k] = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        check("msb_q",     32'(if0.q),       32'(m_q[0]));
        check("msb_valid", 32'(if0.q_valid), 32'(m_qv[0]));
        check("msb_ovf",   32'(if0.ovf),     32'(m_ovf[0]));
        check("msb_busy",  32'(if0.busy),    32'(m_busy[0]));
        check("lsb_q",     32'(if1.q),       32'(m_q[1]));
        check("lsb_valid", 32'(if1.q_valid), 32'(m_qv[1]));
        check("lsb_ovf",   32'(if1.ovf),     32'(m_ovf[1]));
        check("lsb_busy",  32'(if1.busy),    32'(m_busy[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, 1'b1);
        model_step(1, 1'b0);
        @(negedge clk);
        check_all();
    endtask

    task automatic send_bit(input bit b, input bit s, input int gap);
        ser_in = b;
        ser_en = 1'b1;
        sync   = s;
        tick();
        ser_en = 1'b0;
        sync   = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic do_reset();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        clr     = 1'b1;
        ser_in  = 1'b0;
        ser_en  = 1'b0;
        sync    = 1'b0;
        q_ready = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        check("rst_q",     32'(if0.q),       32'h0);
        check("rst_valid", 32'(if0.q_valid), 32'h0);
        check("rst_ovf",   32'(if0.ovf),     32'h0);
        check("rst_busy",  32'(if0.busy),    32'h0);

        // Basic word 1,0,1,1 back to back
        send_bit(1'b1, 1'b1, 0);
        check("basic_busy_b2", 32'(if0.busy), 32'h1);
        send_bit(1'b0, 1'b0, 0);
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b1, 1'b0, 0);
        check("basic_q_msb",   32'(if0.q),       32'hB);
        check("basic_q_lsb",   32'(if1.q),       32'hD);
        check("basic_valid",   32'(if0.q_valid), 32'h1);
        check("basic_busy_end", 32'(if0.busy),   32'h0);
        tick();
        check("basic_valid_1cyc", 32'(if0.q_valid), 32'h0);
        check("basic_ovf",        32'(if0.ovf),     32'h0);

        // Bits 1,1,0,0 with two idle cycles between strobes
        send_bit(1'b1, 1'b1, 2);
        send_bit(1'b1, 1'b0, 2);
        send_bit(1'b0, 1'b0, 2);
        check("gap_no_early_valid", 32'(if1.q_valid), 32'h0);
        check("gap_busy_hold",      32'(if1.busy),    32'h1);
        send_bit(1'b0, 1'b0, 0);
        check("gap_q_lsb", 32'(if1.q),       32'h3);
        check("gap_q_msb", 32'(if0.q),       32'hC);
        check("gap_valid", 32'(if1.q_valid), 32'h1);
        tick();

        // Back-pressure: 4'hA then 4'h5 with nobody accepting
        q_ready = 1'b0;
        send_bit(1'b1, 1'b1, 0);
        send_bit(1'b0, 1'b0, 0);
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b0, 1'b0, 1);
        check("bp_first_q",   32'(if0.q),   32'hA);
        check("bp_first_ovf", 32'(if0.ovf), 32'h0);
        send_bit(1'b0, 1'b1, 0);
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b0, 1'b0, 0);
        send_bit(1'b1, 1'b0, 1);
        check("bp_q_held",   32'(if0.q),       32'hA);
        check("bp_q_held_l", 32'(if1.q),       32'h5);
        check("bp_valid",    32'(if0.q_valid), 32'h1);
        check("bp_ovf",      32'(if0.ovf),     32'h1);
        q_ready = 1'b1;
        tick();
        check("bp_drain_valid", 32'(if0.q_valid), 32'h0);
        check("bp_ovf_sticky",  32'(if0.ovf),     32'h1);
        tick();
        check("bp_ovf_sticky2", 32'(if0.ovf),     32'h1);

        // Accept and complete on the same edge
        do_reset();
        q_ready = 1'b0;
        send_bit(1'b0, 1'b1, 0);
        send_bit(1'b0, 1'b0, 0);
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b1, 1'b0, 1);
        check("acc_hold_q", 32'(if0.q), 32'h3);
        send_bit(1'b1, 1'b1, 0);
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b0, 1'b0, 0);
        check("acc_pre_q", 32'(if0.q), 32'h3);
        q_ready = 1'b1;
        send_bit(1'b0, 1'b0, 0);
        check("acc_q_msb", 32'(if0.q),       32'hC);
        check("acc_q_lsb", 32'(if1.q),       32'h3);
        check("acc_valid", 32'(if0.q_valid), 32'h1);
        check("acc_ovf",   32'(if0.ovf),     32'h0);
        tick();

        // Resync mid-word, then stray bits in IDLE without SYNC
        send_bit(1'b1, 1'b1, 0);
        send_bit(1'b0, 1'b0, 0);
        send_bit(1'b0, 1'b1, 0);
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b0, 1'b0, 0);
        check("resync_q_msb", 32'(if0.q),       32'h6);
        check("resync_q_lsb", 32'(if1.q),       32'h6);
        check("resync_ovf",   32'(if0.ovf),     32'h0);
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b1, 1'b0, 0);
            check("nosync_busy", 32'(if0.busy), 32'h0);
        end
        check("nosync_q", 32'(if0.q), 32'h6);

        // Reset in the middle of a word, with an overflow pending
        q_ready = 1'b0;
        send_bit(1'b1, 1'b1, 0);
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b0, 1'b1, 0);
        send_bit(1'b0, 1'b0, 0);
        send_bit(1'b0, 1'b0, 0);
        send_bit(1'b0, 1'b0, 0);
        check("pre_rst_ovf", 32'(if0.ovf), 32'h1);
        q_ready = 1'b1;
        send_bit(1'b1, 1'b1, 0);
        send_bit(1'b0, 1'b0, 0);
        check("mid_busy", 32'(if0.busy), 32'h1);
        do_reset();
        check("mid_rst_busy",  32'(if0.busy),    32'h0);
        check("mid_rst_q",     32'(if0.q),       32'h0);
        check("mid_rst_valid", 32'(if0.q_valid), 32'h0);
        check("mid_rst_ovf",   32'(if0.ovf),     32'h0);
        send_bit(1'b1, 1'b1, 1);
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b0, 1'b0, 0);
        check("post_rst_q_msb", 32'(if0.q),       32'hE);
        check("post_rst_q_lsb", 32'(if1.q),       32'h7);
        check("post_rst_valid", 32'(if0.q_valid), 32'h1);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
